// File: rtl/time_keep_ctrl.sv
// 24-hour BCD time-of-day keeper with IDLE/RUN/PAUSE control and manual
// minute/hour adjust while stopped; all outputs registered.
module time_keep_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       start_pulse,
  input  logic       pause_pulse,
  input  logic       min_pulse,
  input  logic       hour_pulse,
  output logic [1:0] hr1,
  output logic [3:0] hr0,
  output logic [2:0] min1,
  output logic [3:0] min0,
  output logic [2:0] sec1,
  output logic [3:0] sec0,
  output logic [1:0] state,
  output logic       day_wrap
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t cur, nxt;

  logic [1:0] n_hr1;
  logic [3:0] n_hr0;
  logic [2:0] n_min1;
  logic [3:0] n_min0;
  logic [2:0] n_sec1;
  logic [3:0] n_sec0;
  logic       n_wrap;

  logic [1:0] inc_hr1;
  logic [3:0] inc_hr0;
  logic [2:0] inc_min1;
  logic [3:0] inc_min0;
  logic       sec_max, min_max, hr_max;
  logic       count, adjust;

  assign state = cur;

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start_pulse) nxt = RUN;
      RUN:     if (pause_pulse) nxt = PAUSE;
      PAUSE:   if (start_pulse || pause_pulse) nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  assign sec_max = (sec1 == 3'd5) && (sec0 == 4'd9);
  assign min_max = (min1 == 3'd5) && (min0 == 4'd9);
  assign hr_max  = (hr1 == 2'd2) && (hr0 == 4'd3);
  assign count   = (cur == RUN) && tick_1hz;
  assign adjust  = (cur == IDLE) || (cur == PAUSE);

  // Shared mod-60 / mod-24 incrementers used by both the carry chain and adjust.
  always_comb begin
    inc_min0 = min0 + 4'd1;
    inc_min1 = min1;
    if (min0 == 4'd9) begin
      inc_min0 = '0;
      inc_min1 = min_max ? '0 : min1 + 3'd1;
    end
    inc_hr0 = hr0 + 4'd1;
    inc_hr1 = hr1;
    if (hr_max) begin
      inc_hr0 = '0;
      inc_hr1 = '0;
    end else if (hr0 == 4'd9) begin
      inc_hr0 = '0;
      inc_hr1 = hr1 + 2'd1;
    end
  end

  always_comb begin
    n_hr1  = hr1;
    n_hr0  = hr0;
    n_min1 = min1;
    n_min0 = min0;
    n_sec1 = sec1;
    n_sec0 = sec0;
    n_wrap = 1'b0;
    if (count) begin
      if (sec0 != 4'd9) begin
        n_sec0 = sec0 + 4'd1;
      end else begin
        n_sec0 = '0;
        if (sec1 != 3'd5) begin
          n_sec1 = sec1 + 3'd1;
        end else begin
          n_sec1 = '0;
          n_min1 = inc_min1;
          n_min0 = inc_min0;
          if (min_max) begin
            n_hr1 = inc_hr1;
            n_hr0 = inc_hr0;
          end
        end
      end
      n_wrap = sec_max && min_max && hr_max;
    end else if (adjust) begin
      if (min_pulse) begin
        n_min1 = inc_min1;
        n_min0 = inc_min0;
      end
      if (hour_pulse) begin
        n_hr1 = inc_hr1;
        n_hr0 = inc_hr0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= IDLE;
      hr1      <= '0;
      hr0      <= '0;
      min1     <= '0;
      min0     <= '0;
      sec1     <= '0;
      sec0     <= '0;
      day_wrap <= 1'b0;
    end else begin
      cur      <= nxt;
      hr1      <= n_hr1;
      hr0      <= n_hr0;
      min1     <= n_min1;
      min0     <= n_min0;
      sec1     <= n_sec1;
      sec0     <= n_sec0;
      day_wrap <= n_wrap;
    end
  end

endmodule

// File: tb/tb_time_keep_ctrl.sv
// Directed bench for time_keep_ctrl: a vector table for single-cycle control
// behaviour plus hand sequences for long counts, rollover and reset.
module tb_time_keep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, start_pulse, pause_pulse, min_pulse, hour_pulse;
  logic [1:0] hr1;
  logic [3:0] hr0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic [2:0] sec1;
  logic [3:0] sec0;
  logic [1:0] state;
  logic       day_wrap;
  logic [23:0] tm;

  int unsigned passed = 0;
  int unsigned total  = 0;

  time_keep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start_pulse(start_pulse),
    .pause_pulse(pause_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
    .state(state), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  // Time packed as hex-BCD hhmmss for compact expected values.
  assign tm = {2'b00, hr1, hr0, 1'b0, min1, min0, 1'b0, sec1, sec0};

  typedef struct {
    logic        rst_n, tick, start, pause, mn, hr;
    logic [1:0]  st;
    logic [23:0] tm;
    logic        dw;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic r, t, s, p, m, h,
                              input logic [1:0] st, input logic [23:0] tv,
                              input logic dw);
    vec_t v;
    v.rst_n = r; v.tick = t; v.start = s; v.pause = p; v.mn = m; v.hr = h;
    v.st = st; v.tm = tv; v.dw = dw;
    return v;
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_all(input string name, input logic [1:0] st,
                           input logic [23:0] tv, input logic dw);
    check({name, " state"}, {22'd0, state}, {22'd0, st});
    check({name, " time"}, tm, tv);
    check({name, " day_wrap"}, {23'd0, day_wrap}, {23'd0, dw});
  endtask

  task automatic cyc(input logic r, t, s, p, m, h);
    rst_n = r; tick_1hz = t; start_pulse = s; pause_pulse = p;
    min_pulse = m; hour_pulse = h;
    @(posedge clk);
    #1;
    rst_n = 1'b1; tick_1hz = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
    min_pulse = 1'b0; hour_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
    min_pulse = 1'b0; hour_pulse = 1'b0;

    //               rst tick st  pa  mn  hr   state   time       dw
    vecs[0]  = mk(1, 0, 0, 1, 0, 0, 2'b00, 24'h000000, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0, 0, 2'b01, 24'h000000, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 2'b01, 24'h000001, 0);
    vecs[3]  = mk(1, 1, 0, 0, 1, 0, 2'b01, 24'h000002, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 1, 2'b01, 24'h000002, 0);
    vecs[5]  = mk(1, 1, 1, 0, 0, 0, 2'b01, 24'h000003, 0);
    vecs[6]  = mk(1, 1, 0, 1, 0, 0, 2'b10, 24'h000004, 0);
    vecs[7]  = mk(1, 1, 0, 0, 0, 0, 2'b10, 24'h000004, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, 0, 2'b10, 24'h000104, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 2'b10, 24'h010104, 0);
    vecs[10] = mk(1, 0, 0, 0, 1, 1, 2'b10, 24'h020204, 0);
    vecs[11] = mk(1, 0, 0, 1, 0, 0, 2'b01, 24'h020204, 0);
    vecs[12] = mk(1, 1, 1, 1, 0, 0, 2'b10, 24'h020205, 0);
    vecs[13] = mk(1, 0, 1, 0, 0, 0, 2'b01, 24'h020205, 0);
    vecs[14] = mk(1, 1, 0, 0, 0, 0, 2'b01, 24'h020206, 0);
    vecs[15] = mk(0, 1, 1, 0, 1, 1, 2'b00, 24'h000000, 0);
    vecs[16] = mk(1, 1, 0, 0, 0, 0, 2'b00, 24'h000000, 0);

    do_reset();
    check_all("reset", 2'b00, 24'h000000, 0);

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].rst_n, vecs[i].tick, vecs[i].start, vecs[i].pause,
          vecs[i].mn, vecs[i].hr);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tm, vecs[i].dw);
    end

    // 61 seconds from a fresh start
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    ticks(61);
    check_all("count61", 2'b01, 24'h000101, 0);

    // Adjust wraps at 00:59:30 in PAUSE
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    ticks(30);
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 1, 0);
    check_all("preload_005930", 2'b10, 24'h005930, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check_all("min_wrap", 2'b10, 24'h000030, 0);
    for (int i = 0; i < 24; i++) cyc(1, 0, 0, 0, 0, 1);
    check_all("hour_x24", 2'b10, 24'h000030, 0);
    cyc(1, 0, 0, 0, 1, 1);
    check_all("min_hour_same", 2'b10, 24'h010130, 0);

    // Day rollover from 23:59:58
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    ticks(58);
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 23; i++) cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 1, 0);
    check_all("preload_235958", 2'b10, 24'h235958, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_all("tick_235959", 2'b01, 24'h235959, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_all("day_rollover", 2'b01, 24'h000000, 1);
    cyc(1, 0, 0, 0, 0, 0);
    check_all("wrap_one_cycle", 2'b01, 24'h000000, 0);

    // Reset mid-count at 12:34:56
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 34; i++) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    ticks(56);
    check_all("run_123456", 2'b01, 24'h123456, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check_all("reset_midrun", 2'b00, 24'h000000, 0);
    ticks(5);
    check_all("ticks_after_reset", 2'b00, 24'h000000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/time_keep_ctrl.md
TIME_KEEP_CTRL -- requirements
Module: time_keep_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-003 SHALL have port tick_1hz, input, 1, one-clk-wide enable pulse at 1 Hz, synchronous to clk.
REQ-004 SHALL have port start_pulse, input, 1, one-clk-wide start request.
REQ-005 SHALL have port pause_pulse, input, 1, one-clk-wide pause/resume request.
REQ-006 SHALL have port min_pulse, input, 1, one-clk-wide minute-adjust request.
REQ-007 SHALL have port hour_pulse, input, 1, one-clk-wide hour-adjust request.
REQ-008 SHALL have port hr1, output, 2, hours tens digit, BCD 0-2.
REQ-009 SHALL have port hr0, output, 4, hours units digit, BCD 0-9.
REQ-010 SHALL have port min1, output, 3, minutes tens digit, BCD 0-5.
REQ-011 SHALL have port min0, output, 4, minutes units digit, BCD 0-9.
REQ-012 SHALL have port sec1, output, 3, seconds tens digit, BCD 0-5.
REQ-013 SHALL have port sec0, output, 4, seconds units digit, BCD 0-9.
REQ-014 SHALL have port state, output, 2, FSM state: 2'b00 IDLE, 2'b01 RUN, 2'b10 PAUSE.
REQ-015 SHALL have port day_wrap, output, 1, one-clk pulse on rollover 23:59:59 -> 00:00:00.

Function
REQ-016 SHALL register all outputs; any input effect is visible at the edge following the sampled input (1-cycle latency).
REQ-017 SHALL, in IDLE: start_pulse -> RUN; pause_pulse ignored.
REQ-018 SHALL, in RUN: pause_pulse -> PAUSE; start_pulse ignored; if both asserted, PAUSE.
REQ-019 SHALL, in PAUSE: start_pulse or pause_pulse -> RUN.
REQ-020 SHALL never enter encoding 2'b11; if reached, return to IDLE on the next edge without modifying the time digits.
REQ-021 SHALL advance time by one second on tick_1hz only when the current (registered) state is RUN; a tick coinciding with IDLE->RUN is not counted, and a tick coinciding with RUN->PAUSE is counted.
REQ-022 SHALL carry seconds 59 -> 00 into minutes, minutes 59 -> 00 into hours, and hours 23 -> 00, with BCD digit rollover at 9.
REQ-023 SHALL assert day_wrap for exactly one cycle on the edge where time goes 23:59:59 -> 00:00:00; otherwise 0.
REQ-024 SHALL, in IDLE or PAUSE only, increment minutes mod 60 on min_pulse with no carry into hours and seconds unchanged.
REQ-025 SHALL, in IDLE or PAUSE only, increment hours mod 24 on hour_pulse.
REQ-026 SHALL apply min_pulse and hour_pulse independently when asserted in the same cycle.
REQ-027 SHALL ignore min_pulse and hour_pulse while in RUN.
REQ-028 SHALL never produce a digit outside its BCD range; day_wrap SHALL not assert on adjust-induced wraps.

Reset
REQ-029 SHALL, when rst_n = 0 at an edge, set state = IDLE, all digits = 0 and day_wrap = 0, overriding all other inputs.
REQ-030 SHALL, on reset asserted mid-count, clear time and state on that edge; counting resumes only after a new start_pulse.

Verification
REQ-031 SHALL cover: reset; start_pulse; 61 ticks -> state=01, time 00:01:01.
REQ-032 SHALL cover: preload 23:59:58 in PAUSE; start; 2 ticks -> 00:00:00, day_wrap high exactly one cycle on the second tick.
REQ-033 SHALL cover: in PAUSE at 00:59:30, min_pulse -> 00:00:30; hour_pulse x24 -> 00:00:30; min_pulse+hour_pulse same cycle -> 01:01:30.
REQ-034 SHALL cover: in RUN, min_pulse/hour_pulse/start_pulse -> time and state unchanged apart from ticks; pause_pulse with tick in the same cycle -> state=10, the tick is counted.
REQ-035 SHALL cover: in IDLE, start_pulse with tick in the same cycle -> state=01, seconds stay 00; pause_pulse in IDLE -> no change.
REQ-036 SHALL cover: rst_n low for one edge while in RUN at 12:34:56 -> next cycle state=00, time 00:00:00, subsequent ticks ignored.
